uart_rx: RTL
============

# uart_rx

UART receiver, the receive-side counterpart of `uart_tx`. It recovers 8N1 frames (1 start bit, 8 data bits LSB first, 1 stop bit, no parity) from the asynchronous `rx` pin using a fixed clocks-per-bit divider. It presents each byte with a one-cycle `valid` strobe to downstream logic such as a command parser or a FIFO. It shares the `CLK_PER_BAUD` parameter with `uart_tx`, so a tx/rx pair built with the same value interoperates in loopback.

## Interface
- `CLK_PER_BAUD`, default 104 (12 MHz / 115200): clock cycles per bit.
  - Legal range is ≥ 4.
  - H = `CLK_PER_BAUD`/2 (integer floor) is the half-bit count.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  reset, asynchronous assert, active-low: 0 = reset.
- `rx`  in  1  serial input, asynchronous to `clk`; idle level is 1.
- `rx_byte`  out  8  last correctly received byte; holds its value until the next good frame.
- `valid`  out  1  one-cycle pulse; `rx_byte` is new and stable during this cycle.
- `frame_err`  out  1  one-cycle pulse; stop bit was sampled low.

## Operation
- Input synchronizer: 2-flop chain `rx` → s1 → s2; the FSM uses only s2.
  - Both flops reset to 1, so reset does not look like a start bit.
- Counters:
  - `cnt` is wide enough for `CLK_PER_BAUD`-1.
  - `bit_idx` is 3 bits.
  - Shift register is 8 bits, filled LSB first: bit i goes to position i.
- States: IDLE, START, DATA, STOP, BREAK.
- IDLE:
  - s2 = 0 → START, `cnt` ← 0.
  - Otherwise stay in IDLE.
- START:
  - `cnt` increments each cycle.
  - At `cnt` = H-1, check s2.
  - s2 = 0 → DATA, `cnt` ← 0, `bit_idx` ← 0.
  - s2 = 1 → IDLE (false start / glitch). Nothing is reported.
- DATA:
  - At `cnt` = `CLK_PER_BAUD`-1: shift[`bit_idx`] ← s2, `cnt` ← 0, `bit_idx` += 1.
  - After bit 7 is sampled → STOP.
- STOP, at `cnt` = `CLK_PER_BAUD`-1:
  - s2 = 1 → `rx_byte` ← shift, `valid` ← 1, → IDLE.
  - s2 = 0 → `frame_err` ← 1, `rx_byte` unchanged, → BREAK.
- BREAK: wait for s2 = 1, then → IDLE. This means a held-low line (break) yields exactly one `frame_err` and no spurious frames.
- Return to IDLE happens at mid-stop-bit. The next start edge is therefore caught even with zero idle time between frames, and the receiver tolerates about ±4% baud mismatch.
- `valid` and `frame_err` are registered and never high together.
- Reset values: `rx_byte` = 0x00, `valid` = 0, `frame_err` = 0, state IDLE, counters 0, shift register 0.
- Reset mid-frame: the partial frame is discarded with no pulse. After release, the receiver resynchronises on the next falling edge seen while in IDLE.
  - If the line is low during release, the remainder of a frame may be mis-framed. Only `frame_err`/`valid` may result; no lock-up is allowed.

## Timing
- Let E be the clock edge at which s1 first captures `rx` = 0 while the FSM is in IDLE.
  - s2 = 0 after E+1.
  - FSM enters START at E+2.
- Start check at edge E+2+H. This samples the pin as seen at edge E+H, i.e. mid start bit.
- Data bit i is sampled at edge E+2+H+(i+1)·C, for i = 0..7, where C = `CLK_PER_BAUD`.
- Stop bit is sampled at edge E+2+H+9·C.
  - `valid` or `frame_err` is high for exactly the following cycle.
  - `rx_byte` updates on the same edge as `valid`.
- Worked example, C = 4, H = 2: `valid` rises at edge E+40.
- Minimum low pulse recognised as a start: must still be low at E+H. Glitches shorter than H cycles are rejected.
- Throughput: one byte per 10·C cycles, sustained, with back-to-back frames.

## Test plan
- Single frame: C = 4, drive byte 0x30 ('0') at 4 clk/bit → `rx_byte` = 0x30, `valid` high for exactly 1 cycle at E+40, `frame_err` stays 0.
- Back-to-back: frames 0x55, 0xAA, 0x00, 0xFF with no idle bits.
  - Expect 4 `valid` pulses exactly 40 cycles apart, with the bytes in order.
- Glitch: C = 8, `rx` low for 3 cycles, then high → no `valid`, no `frame_err`, FSM back in IDLE.
  - A following 0xA5 frame is received correctly.
- Framing error: frame 0x3C with stop bit driven 0, then line held low 30 cycles, then high.
  - Exactly one `frame_err` pulse, no `valid`, `rx_byte` keeps its previous value.
  - Next frame 0x81 → `valid` with `rx_byte` = 0x81.
- Reset mid-frame: assert `rst` = 0 after data bit 3 of 0xF0.
  - Outputs go to 0 asynchronously.
  - After release plus a fresh 0x12 frame → `valid` with 0x12 and no earlier pulse.
- Loopback: `uart_tx` (same C = 4, `start_send` = 1, `tx_byte` = "0") drives `rx` → repeated `valid` with `rx_byte` = 0x30, and `frame_err` never asserts.

Source files
------------

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx -- 8N1 UART receiver with a fixed clocks-per-bit divider.
//
// Recovers frames of 1 start bit, 8 data bits (LSB first) and 1 stop bit from
// the asynchronous rx pin. A good frame loads rx_byte and pulses valid for one
// cycle; a low stop bit pulses frame_err for one cycle. After a low stop bit
// the receiver stays in a break state until the line returns high, so a held
// low line reports exactly one frame_err.
//
// Parameters
//   CLK_PER_BAUD : clock cycles per bit (>= 4). H = CLK_PER_BAUD/2.
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous reset, active low (0 = reset)
//   rx         in   serial input, asynchronous to clk, idles high
//   rx_byte    out  last correctly received byte, held until the next good frame
//   valid      out  one-cycle pulse, rx_byte is new during this cycle
//   frame_err  out  one-cycle pulse, stop bit was sampled low
// -----------------------------------------------------------------------------
module uart_rx #(
   parameter int CLK_PER_BAUD = 104
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] rx_byte,
   output logic       valid,
   output logic       frame_err
);

   localparam int CW = (CLK_PER_BAUD > 1) ? $clog2(CLK_PER_BAUD) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(CLK_PER_BAUD - 1);
   localparam logic [CW-1:0] CNT_HALF = CW'(CLK_PER_BAUD / 2 - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_DATA  = 3'd2,
      ST_STOP  = 3'd3,
      ST_BREAK = 3'd4
   } state_t;

   logic          s1_q, s1_d;
   logic          s2_q, s2_d;
   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    bit_idx_q, bit_idx_d;
   logic [7:0]    shift_q, shift_d;
   logic [7:0]    rx_byte_q, rx_byte_d;
   logic          valid_q, valid_d;
   logic          frame_err_q, frame_err_d;

   // Two-flop synchroniser inputs; both stages reset high so reset never
   // looks like a start bit.
   always_comb begin
      s1_d = rx;
      s2_d = s1_q;
   end

   // Receive FSM: next state, counters, shift register and output pulses.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      bit_idx_d   = bit_idx_q;
      shift_d     = shift_q;
      rx_byte_d   = rx_byte_q;
      valid_d     = 1'b0;
      frame_err_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (!s2_q) begin
               state_d = ST_START;
               cnt_d   = '0;
            end else begin
               state_d = ST_IDLE;
            end
         end

         // Re-check the line at mid start bit; a high level there was a glitch.
         ST_START: begin
            if (cnt_q == CNT_HALF) begin
               if (!s2_q) begin
                  state_d   = ST_DATA;
                  cnt_d     = '0;
                  bit_idx_d = 3'd0;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end

         // Sampling a full bit period after mid start lands on mid data bit.
         ST_DATA: begin
            if (cnt_q == CNT_LAST) begin
               shift_d[bit_idx_q] = s2_q;
               cnt_d              = '0;
               bit_idx_d          = bit_idx_q + 3'd1;
               if (bit_idx_q == 3'd7) begin
                  state_d = ST_STOP;
               end else begin
                  state_d = ST_DATA;
               end
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end

         // Leaving at mid stop bit leaves half a bit to catch the next start.
         ST_STOP: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d = '0;
               if (s2_q) begin
                  rx_byte_d = shift_q;
                  valid_d   = 1'b1;
                  state_d   = ST_IDLE;
               end else begin
                  frame_err_d = 1'b1;
                  state_d     = ST_BREAK;
               end
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end

         // Held-low line: wait for idle level before hunting for a start bit.
         ST_BREAK: begin
            if (s2_q) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_BREAK;
            end
         end

         default: begin
            state_d   = ST_IDLE;
            cnt_d     = '0;
            bit_idx_d = 3'd0;
         end
      endcase
   end

   // State and datapath registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_q        <= 1'b1;
         s2_q        <= 1'b1;
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         bit_idx_q   <= 3'd0;
         shift_q     <= 8'h00;
         rx_byte_q   <= 8'h00;
         valid_q     <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         s1_q        <= s1_d;
         s2_q        <= s2_d;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bit_idx_q   <= bit_idx_d;
         shift_q     <= shift_d;
         rx_byte_q   <= rx_byte_d;
         valid_q     <= valid_d;
         frame_err_q <= frame_err_d;
      end
   end

   assign rx_byte   = rx_byte_q;
   assign valid     = valid_q;
   assign frame_err = frame_err_q;

endmodule
